irq_scheduler: RTL and testbench

- Interrupt source scheduler between external/peripheral IRQ lines and the machine-mode interrupt client.
- Latches per-source pending state and masks it by a software enable register.
- Selects one winner, raises a single request toward the client, and tracks one in-service interrupt through a claim/complete handshake.
- Software sees a small memory-mapped register window on the data bus.

---
 rtl/irq_scheduler_pkg.sv | 15 +
 rtl/irq_prio_enc.sv | 37 +++
 rtl/irq_scheduler.sv | 138 +++++++++++++
 tb/tb_irq_scheduler.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_scheduler_pkg.sv
// Shared constants for the interrupt scheduler: register window offsets and FSM state encodings.
package irq_scheduler_pkg;

  localparam logic [3:0] IRQS_ENABLE  = 4'h0;
  localparam logic [3:0] IRQS_PENDING = 4'h4;
  localparam logic [3:0] IRQS_CLAIM   = 4'h8;
  localparam logic [3:0] IRQS_EDGE    = 4'hC;

  typedef enum logic [1:0] {
    IRQS_IDLE = 2'd0,
    IRQS_REQ  = 2'd1,
    IRQS_SERV = 2'd2
  } irqs_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational winner picker: first set bit of i_mask searching upward from i_start, wrapping.
// With i_start tied to 0 this is plain lowest-index-wins priority.
module irq_prio_enc #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 5
) (
  input  logic [N_SRC-1:0] i_mask,
  input  logic [ID_W-1:0]  i_start,
  output logic [ID_W-1:0]  o_id,
  output logic             o_valid
);

  localparam logic [ID_W:0] L_NSRC = (ID_W+1)'(N_SRC);

  logic [N_SRC-1:0] w_rot;
  logic [ID_W-1:0]  w_pos;
  logic [ID_W:0]    w_sum;

  // Rotate so bit 0 of w_rot is the source at i_start; i_start is always below N_SRC.
  assign w_rot = N_SRC'({i_mask, i_mask} >> i_start);

  always_comb begin
    w_pos = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (w_rot[k]) w_pos = ID_W'(k);
    end
  end

  always_comb begin
    w_sum = {1'b0, w_pos} + {1'b0, i_start};
    if (w_sum >= L_NSRC) w_sum = w_sum - L_NSRC;
  end

  assign o_valid = |i_mask;
  assign o_id    = o_valid ? ID_W'(w_sum + (ID_W+1)'(1)) : '0;

endmodule

// File: rtl/irq_scheduler.sv
// Interrupt scheduler: per-source pending latch, enable mask, single request with claim/complete.
// Build option IRQ_RR_EN selects round-robin priority instead of fixed lowest-index priority.
module irq_scheduler
  import irq_scheduler_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int ID_W  = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N_SRC-1:0] src_irq,
  input  logic             global_int_en,
  input  logic             bus_we,
  input  logic             bus_re,
  input  logic [3:0]       bus_addr,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  output logic             irq_req,
  output logic [ID_W-1:0]  irq_id,
  output logic             in_service,
  output logic [1:0]       o_dbg_state
);

  irqs_state_e      r_state, w_state_nxt;
  logic [N_SRC-1:0] r_enable, r_edge, r_pend, r_prev;
  logic [ID_W-1:0]  r_irq_id, r_serv_id;
  logic [31:0]      r_rdata;

  logic [N_SRC-1:0] w_elig, w_serv_mask, w_claim_mask, w_pend_nxt;
  logic [ID_W-1:0]  w_win_id, w_start;
  logic             w_win_vld, w_req, w_claim_rd, w_claim, w_complete;
  logic [31:0]      w_rd_mux;
  logic             w_unused;

  assign w_unused = &{1'b0, bus_wdata};

  always_comb begin
    w_serv_mask  = '0;
    w_claim_mask = '0;
    for (int k = 0; k < N_SRC; k++) begin
      w_serv_mask[k]  = (r_serv_id == ID_W'(k + 1));
      w_claim_mask[k] = w_claim && (r_irq_id == ID_W'(k + 1));
    end
  end

  assign w_elig = r_pend & r_enable & ~w_serv_mask;

  // Edge sources: a new rising edge beats a claim clear in the same cycle.
  assign w_pend_nxt = (r_edge & ((r_pend & ~w_claim_mask) | (src_irq & ~r_prev)))
                    | (~r_edge & src_irq);

`ifdef IRQ_RR_EN
  logic [ID_W-1:0] r_rr_ptr;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_rr_ptr <= '0;
    end else if (w_claim) begin
      r_rr_ptr <= (r_irq_id >= ID_W'(N_SRC)) ? '0 : r_irq_id;
    end
  end

  assign w_start = r_rr_ptr;
`else
  assign w_start = '0;
`endif

  irq_prio_enc #(.N_SRC(N_SRC), .ID_W(ID_W)) u_prio_enc (
    .i_mask  (w_elig),
    .i_start (w_start),
    .o_id    (w_win_id),
    .o_valid (w_win_vld)
  );

  assign w_claim_rd = bus_re && (bus_addr == IRQS_CLAIM);
  assign w_claim    = w_req && w_claim_rd;
  assign w_complete = (r_state == IRQS_SERV) && bus_we && (bus_addr == IRQS_CLAIM)
                    && (bus_wdata[ID_W-1:0] == r_serv_id);

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    case (r_state)
      IRQS_IDLE: if (w_win_vld && global_int_en) w_state_nxt = IRQS_REQ;
      IRQS_REQ: begin
        if (!(w_win_vld && global_int_en)) begin
          w_state_nxt = IRQS_IDLE;
        end else begin
          w_req = 1'b1;
          if (w_claim_rd) w_state_nxt = IRQS_SERV;
        end
      end
      IRQS_SERV: if (w_complete) w_state_nxt = IRQS_IDLE;
      default:   w_state_nxt = IRQS_IDLE;
    endcase
  end

  always_comb begin
    w_rd_mux = '0;
    case (bus_addr)
      IRQS_ENABLE:  w_rd_mux = 32'(r_enable);
      IRQS_PENDING: w_rd_mux = 32'(r_pend);
      IRQS_CLAIM:   w_rd_mux = w_claim ? 32'(r_irq_id) : 32'd0;
      IRQS_EDGE:    w_rd_mux = 32'(r_edge);
      default:      w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= IRQS_IDLE;
      r_enable  <= '0;
      r_edge    <= '0;
      r_pend    <= '0;
      r_prev    <= '0;
      r_irq_id  <= '0;
      r_serv_id <= '0;
      r_rdata   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_prev   <= src_irq;
      r_pend   <= w_pend_nxt;
      r_irq_id <= w_win_id;
      if (bus_we && (bus_addr == IRQS_ENABLE)) r_enable <= bus_wdata[N_SRC-1:0];
      if (bus_we && (bus_addr == IRQS_EDGE))   r_edge   <= bus_wdata[N_SRC-1:0];
      if (bus_re) r_rdata <= w_rd_mux;
      if (w_claim)         r_serv_id <= r_irq_id;
      else if (w_complete) r_serv_id <= '0;
    end
  end

  assign bus_rdata   = r_rdata;
  assign irq_req     = w_req;
  assign irq_id      = r_irq_id;
  assign in_service  = (r_state == IRQS_SERV);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_irq_scheduler.sv
// Self-checking bench for irq_scheduler: directed scenarios then randomized traffic,
// every cycle compared against a behavioural model of the scheduler rules.
module tb_irq_scheduler;
  import irq_scheduler_pkg::*;

  localparam int N  = 8;
  localparam int IW = 5;
`ifdef IRQ_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // clock / reset
  logic          clk = 1'b0;
  logic          clr, gie, we, re;
  logic [N-1:0]  src;
  logic [3:0]    addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          irq_req, in_service;
  logic [IW-1:0] irq_id;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  irq_scheduler #(.N_SRC(N), .ID_W(IW)) dut (
    .clk           (clk),
    .clr           (clr),
    .src_irq       (src),
    .global_int_en (gie),
    .bus_we        (we),
    .bus_re        (re),
    .bus_addr      (addr),
    .bus_wdata     (wdata),
    .bus_rdata     (rdata),
    .irq_req       (irq_req),
    .irq_id        (irq_id),
    .in_service    (in_service),
    .o_dbg_state   (dbg_state)
  );

  // scoreboard
  int          n_total = 0;
  int          n_bad   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: phase 0 = idle, 1 = requesting, 2 = in service
  logic [N-1:0] m_en, m_edge, m_pend, m_prev;
  int           m_phase, m_serv, m_id, m_ptr;
  logic [31:0]  m_rdata;
  bit           m_rd_pend;
  bit           m_known = 1'b0;

  function automatic int pick(input logic [N-1:0] set, input int start);
    for (int off = 0; off < N; off++) begin
      int idx;
      idx = (start + off) % N;
      if (set[idx]) return idx + 1;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_en = '0; m_edge = '0; m_pend = '0; m_prev = '0;
    m_phase = 0; m_serv = 0; m_id = 0; m_ptr = 0;
    m_rdata = '0; m_rd_pend = 1'b0; exp_q.delete();
    m_known = 1'b1;
  endtask

  // driver: inputs are set after a falling edge; this checks outputs, advances the model
  // by one clock and returns at the next falling edge
  task automatic cycle();
    logic [N-1:0] elig, npend;
    logic         req_now, claim, complete;
    logic [31:0]  rv;
    logic [1:0]   ecode;
    int           nid, nphase;
    #1;
    elig = m_pend & m_en;
    if (m_serv != 0) elig[m_serv-1] = 1'b0;
    req_now = (m_phase == 1) && (elig != '0) && gie;
    if (m_known) begin
      ecode = (m_phase == 0) ? IRQS_IDLE : (m_phase == 1) ? IRQS_REQ : IRQS_SERV;
      chk("irq_req", 32'(irq_req), 32'(req_now));
      chk("irq_id", 32'(irq_id), m_id);
      chk("in_service", 32'(in_service), 32'(m_phase == 2));
      chk("state", 32'(dbg_state), 32'(ecode));
      if (m_rd_pend) chk("rd_data", rdata, exp_q.pop_front());
      else           chk("rd_hold", rdata, m_rdata);
    end
    if (clr) begin
      model_reset();
    end else if (m_known) begin
      claim    = req_now && re && (addr == 4'h8);
      complete = (m_phase == 2) && we && (addr == 4'h8) && (32'(wdata[IW-1:0]) == m_serv);
      m_rd_pend = 1'b0;
      if (re) begin
        case (addr)
          4'h0:    rv = 32'(m_en);
          4'h4:    rv = 32'(m_pend);
          4'h8:    rv = claim ? m_id : 0;
          4'hC:    rv = 32'(m_edge);
          default: rv = '0;
        endcase
        exp_q.push_back(rv);
        m_rdata   = rv;
        m_rd_pend = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
        if (m_edge[i]) npend[i] = (m_pend[i] && !(claim && m_id == i + 1)) || (src[i] && !m_prev[i]);
        else           npend[i] = src[i];
      end
      nid    = pick(elig, RR ? m_ptr : 0);
      nphase = m_phase;
      if (m_phase == 0 && elig != '0 && gie) nphase = 1;
      if (m_phase == 1) nphase = !req_now ? 0 : (claim ? 2 : 1);
      if (m_phase == 2 && complete) nphase = 0;
      if (claim) begin
        m_serv = m_id;
        if (RR) m_ptr = m_id % N;
      end else if (complete) begin
        m_serv = 0;
      end
      if (we && addr == 4'h0) m_en   = wdata[N-1:0];
      if (we && addr == 4'hC) m_edge = wdata[N-1:0];
      m_phase = nphase;
      m_pend  = npend;
      m_prev  = src;
      m_id    = nid;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    cycle();
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a);
    re = 1'b1; addr = a;
    cycle();
    re = 1'b0;
  endtask

  task automatic wait_req(input string tag, input int max_cyc);
    int n = 0;
    while (!irq_req && n < max_cyc) begin
      cycle();
      n++;
    end
    chk(tag, 32'(irq_req), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr = 1'b1; gie = 1'b0; we = 1'b0; re = 1'b0;
    src = '0; addr = '0; wdata = '0;
    @(negedge clk);
    cycle();
    cycle();
    clr = 1'b0;
    chk("rst_req", 32'(irq_req), 32'd0);
    chk("rst_id", 32'(irq_id), 32'd0);
    chk("rst_insvc", 32'(in_service), 32'd0);
    chk("rst_rdata", rdata, 32'd0);

    // levels on sources 1 and 2, lowest index wins
    gie = 1'b1; src = 8'h06;
    bus_write(4'hC, 32'h0);
    bus_write(4'h0, 32'h06);
    wait_req("t1_req", 2);
    chk("t1_id", 32'(irq_id), 32'd2);
    bus_read(4'h8);
    chk("t1_claim", rdata, 32'd2);
    chk("t1_insvc", 32'(in_service), 32'd1);

    // completion only with the matching ID
    bus_write(4'h8, 32'd3);
    chk("t3_still_serv", 32'(in_service), 32'd1);
    bus_write(4'h8, 32'd2);
    chk("t3_done", 32'(in_service), 32'd0);
    cycle();
    chk("t3_rereq", 32'(irq_req), 32'd1);

    // global enable drop while requesting
    gie = 1'b0;
    #1;
    chk("t4_drop", 32'(irq_req), 32'd0);
    cycle();
    chk("t4_idle", 32'(dbg_state), 32'(IRQS_IDLE));
    bus_read(4'h8);
    chk("t4_claim0", rdata, 32'd0);
    bus_read(4'h4);
    chk("t4_pend", rdata, 32'h06);

    // edge source 3 with a one-cycle pulse
    src = '0;
    bus_write(4'h0, 32'h08);
    bus_write(4'hC, 32'h08);
    gie = 1'b1; src = 8'h08;
    cycle();
    src = '0;
    cycle();
    cycle();
    bus_read(4'h4);
    chk("t2_pend", rdata, 32'h08);
    wait_req("t2_req", 4);
    bus_read(4'h8);
    chk("t2_claim", rdata, 32'd4);
    bus_read(4'h4);
    chk("t2_pend_clr", rdata, 32'h00);
    bus_write(4'h8, 32'd4);
    chk("t2_done", 32'(in_service), 32'd0);

    // edge source 0: new rising edge in the claim cycle keeps the bit set
    bus_write(4'hC, 32'h01);
    bus_write(4'h0, 32'h01);
    src = 8'h01;
    cycle();
    src = '0;
    cycle();
    wait_req("t5_req", 4);
    src = 8'h01;
    bus_read(4'h8);
    src = '0;
    chk("t5_claim", rdata, 32'd1);
    bus_read(4'h4);
    chk("t5_pend_kept", rdata, 32'h01);

    // reset while in service, then two claims with sources 1 and 2 pending
    chk("t6_pre", 32'(in_service), 32'd1);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    chk("t6_req", 32'(irq_req), 32'd0);
    chk("t6_id", 32'(irq_id), 32'd0);
    chk("t6_insvc", 32'(in_service), 32'd0);
    chk("t6_rdata", rdata, 32'd0);
    bus_read(4'h0);
    chk("t6_en", rdata, 32'd0);
    src = 8'h06;
    bus_write(4'h0, 32'h06);
    wait_req("t6_req1", 4);
    bus_read(4'h8);
    chk("t6_claim1", rdata, 32'd2);
    bus_write(4'h8, 32'd2);
    wait_req("t6_req2", 4);
    bus_read(4'h8);
    chk("t6_claim2", rdata, RR ? 32'd3 : 32'd2);

    // randomized traffic against the model
    for (int c = 0; c < 2500; c++) begin
      src  = src ^ (N'($urandom_range(0, 255)) & N'($urandom_range(0, 255)));
      gie  = ($urandom_range(0, 9) != 0);
      clr  = ($urandom_range(0, 299) == 0);
      re   = ($urandom_range(0, 2) == 0);
      we   = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 5))
        0:       addr = 4'h0;
        1:       addr = 4'h4;
        2, 3:    addr = 4'h8;
        4:       addr = 4'hC;
        default: addr = 4'($urandom_range(0, 15));
      endcase
      wdata = $urandom();
      if (addr == 4'h8 && m_serv != 0 && $urandom_range(0, 1) == 1) wdata = 32'(m_serv);
      cycle();
    end
    clr = 1'b0; re = 1'b0; we = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
